// File: rtl/spi_sensor_reader_if.sv
// Bus bundle for spi_sensor_reader: sensor-FSM handshake, received word and SPI pins.
// master = the SPI reader itself, slave = the sensor/consumer side.
interface spi_sensor_reader_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              miso;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              busy;

  modport master (
    input  start, miso,
    output sclk, cs_n, mosi, data, data_valid, busy
  );

  modport slave (
    output start, miso,
    input  sclk, cs_n, mosi, data, data_valid, busy
  );
endinterface

// File: rtl/spi_sensor_reader.sv
// Mode-0 SPI master reading one DATA_W-bit sensor word per start strobe.
// Optional command phase (CMD shifted out on mosi first) enabled by SPI_CMD_EN.
module spi_sensor_reader #(
  parameter int         CLK_DIV = 4,
  parameter int         DATA_W  = 16,
  parameter logic [7:0] CMD     = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  spi_sensor_reader_if.master bus
);

`ifdef SPI_CMD_EN
  localparam int N = DATA_W + 8;
`else
  localparam int N = DATA_W;
`endif
  localparam int BW  = $clog2(N + 1);
  localparam int DVW = $clog2(CLK_DIV + 1);

  localparam logic [DVW-1:0] DIV_HALF = DVW'(CLK_DIV - 1);
  localparam logic [DVW-1:0] DIV_FULL = DVW'(CLK_DIV);
  localparam logic [BW-1:0]  BIT_END  = BW'(N);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic [DVW-1:0]    div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              dv_q, dv_d;
  logic              busy_q, busy_d;
`ifdef SPI_CMD_EN
  logic              mosi_q, mosi_d;
  logic [7:0]        cmd_q, cmd_d;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    dv_d    = 1'b0;
    busy_d  = busy_q;
`ifdef SPI_CMD_EN
    mosi_d  = mosi_q;
    cmd_d   = cmd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      // SETUP spans CLK_DIV+1 cycles: cs_n drops one cycle after start is taken
      SETUP: begin
        div_d = div_q + 1'b1;
        if (div_q == '0) begin
          cs_n_d = 1'b0;
          busy_d = 1'b1;
`ifdef SPI_CMD_EN
          mosi_d = CMD[7];
          cmd_d  = {CMD[6:0], 1'b0};
`endif
        end
        if (div_q == DIV_FULL) begin
          state_d = SHIFT;
          div_d   = '0;
          sclk_d  = 1'b1;
          shreg_d = DATA_W'({shreg_q, bus.miso});
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_HALF) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
`ifdef SPI_CMD_EN
            mosi_d = cmd_q[7];
            cmd_d  = {cmd_q[6:0], 1'b0};
`endif
          end else if (bit_q == BIT_END) begin
            state_d = HOLD;
          end else begin
            sclk_d  = 1'b1;
            // command-phase samples simply fall off the top of the register
            shreg_d = DATA_W'({shreg_q, bus.miso});
          end
        end
      end
      HOLD: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_FULL) begin
          state_d = DONE;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          dv_d    = 1'b1;
          data_d  = shreg_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SPI_CMD_EN
      mosi_q  <= 1'b0;
      cmd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
`ifdef SPI_CMD_EN
      mosi_q  <= mosi_d;
      cmd_q   <= cmd_d;
`endif
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.cs_n       = cs_n_q;
  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.busy       = busy_q;
`ifdef SPI_CMD_EN
  assign bus.mosi       = mosi_q;
`else
  logic unused_cmd;
  assign unused_cmd = ^CMD;
  assign bus.mosi   = 1'b0;
`endif

endmodule
